// File: rtl/apb_cpu_master_if.sv
// APB-style bus bundle between the CPU master and the peripheral decoder.
interface apb_cpu_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_cpu_master.sv
// CPU-side bus master: turns MemRead/MemWrite level requests into SETUP/ACCESS
// transfers, stalls the CPU while a transfer is in flight, and reports
// wait-state timeouts and slave errors.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transfer; request latched on the next edge
// SETUP   | PSEL high, PENABLE low, address/data/direction stable
// ACCESS  | PSEL and PENABLE high, waiting for PREADY or timeout
// DONE    | one cycle; CPU released, MemData/BusErr valid
// RELEASE | wait for the CPU to drop its request before accepting another
module apb_cpu_master #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Adress,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] MemData,
  output logic              isLocked,
  output logic              BusErr,
  apb_cpu_master_if.master  apb
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Abort when the increment about to happen would reach TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pwrite;
  logic [DATA_W-1:0] mem_data;
  logic              bus_err;

  logic req;
  logic latch_req;
  logic capture;
  logic abort;

  assign req = MemRead | MemWrite;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and per-cycle transfer events.
  always_comb begin
    state_nx  = state;
    latch_req = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx  = SETUP;
          latch_req = 1'b1;
        end
      end
      SETUP:   state_nx = ACCESS;
      ACCESS: begin
        if (apb.PREADY) begin
          state_nx = DONE;
          capture  = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nx = DONE;
          abort    = 1'b1;
        end
      end
      DONE:    state_nx = RELEASE;
      RELEASE: begin
        // A request still held from the finished transfer is never re-issued.
        if (!req) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ACCESS cycle counter; cleared while in SETUP so it starts at zero, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == SETUP) begin
      cnt <= '0;
    end else if (state == ACCESS && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Request latch and transfer results; bus fields hold their last values when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      mem_data <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (latch_req) begin
        paddr  <= Adress;
        pwdata <= WriteData;
        pwrite <= MemWrite;
      end
      bus_err <= capture ? apb.PSLVERR : abort;
      if (!pwrite) begin
        if (capture)    mem_data <= apb.PSLVERR ? ERR_DATA : apb.PRDATA;
        else if (abort) mem_data <= ERR_DATA;
      end
    end
  end

  // Bus phase and CPU stall decode.
  always_comb begin
    apb.PSEL    = (state == SETUP) || (state == ACCESS);
    apb.PENABLE = (state == ACCESS);
    isLocked    = (state == SETUP) || (state == ACCESS) || ((state == IDLE) && req);
  end

  assign apb.PADDR  = paddr;
  assign apb.PWDATA = pwdata;
  assign apb.PWRITE = pwrite;
  assign MemData    = mem_data;
  assign BusErr     = bus_err;

endmodule
